alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered stage directly downstream of the add/sub arithmetic unit.
- Latches the raw sum S and the flags z, v and n, with ALUFun, Sign and the instruction PC.
- Produces the final execute result: the sum for arithmetic ops, or a 0/1 compare result derived from the flags.
- Detects signed overflow, holds an exception request until the exception controller acknowledges it, and keeps a saturating overflow counter.

Parameters:
- DW, 32, data/result width.
- CNTW, 16, overflow counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream op valid this cycle.
- stall  input  1  hold all stage registers.
- flush  input  1  kill the op in the stage.
- S  input  DW  sum/difference from the arithmetic unit.
- z  input  1  1 = S nonzero, 0 = S zero (this polarity is fixed).
- v  input  1  overflow flag.
- n  input  1  negative/less-than flag.
- ALUFun  input  6  ALU function code.
- Sign  input  1  1 = signed op.
- pc  input  DW  PC of the op.
- out_valid  output  1  registered op valid.
- out_result  output  DW  final result.
- out_wen  output  1  register-file write enable for the result.
- ovf_req  output  1  overflow exception request.
- ovf_pc  output  DW  PC of the faulting op.
- ovf_ack  input  1  exception controller acknowledge.
- ovf_cnt  output  CNTW  saturating count of overflows.

Behaviour:
- Reset (asynchronous, reset=0): all outputs 0. FSM enters IDLE.
- Capture:
  - Capture happens when in_valid=1, stall=0, flush=0.
  - Latency is one cycle: out_valid and out_result update on the next rising edge.
- Stall and flush:
  - stall=1 holds every register. A new capture is blocked.
  - flush=1 clears out_valid and out_wen on the next edge.
  - flush has priority over stall.
  - flush does not clear ovf_req or ovf_cnt.
  - When no capture occurs and stall=0, out_valid is cleared.
- Result select by ALUFun[5:4]:
  - 2'b00 (arithmetic): out_result = S.
  - 2'b11 (compare): out_result = {DW-1 zeros, c}, with c chosen by ALUFun[3:1]:
    - 001 EQ: c = ~z
    - 000 NE: c = z
    - 010 LT: c = n
    - 110 LEZ: c = n | ~z
    - 101 LTZ: c = n
    - 111 GTZ: c = ~n & z
    - any other code: c = 0
  - Other ALUFun[5:4] values: out_result = S.
- Overflow is detected at capture when ALUFun[5:4]=00, Sign=1 and v=1.
  - Unsigned ops (Sign=0) never trap, even when v=1.
- Overflow effects:
  - out_wen = out_valid & ~trap. The faulting result is never written.
  - ovf_cnt increments by 1 and saturates at all-ones.
- FSM:
  - IDLE:
    - On an overflow capture: go to REQ, set ovf_req=1, ovf_pc = pc.
  - REQ:
    - ovf_req stays 1. ovf_pc is stable.
    - On ovf_ack=1 with no new overflow capture: go to IDLE, ovf_req=0 on the next edge.
    - On ovf_ack=1 with a new overflow capture in the same cycle: stay in REQ, ovf_pc = new pc.
    - On a new overflow capture with ovf_ack=0: ovf_pc is kept (first fault wins); ovf_cnt still increments.
  - ovf_ack in IDLE is ignored.
- Reset mid-request clears ovf_req, ovf_pc and ovf_cnt immediately, with no wait for the clock.
- Compare ops never trap, even when v=1.

Test Plan:
- Arithmetic pass-through: S=0x00000005, ALUFun=000000, Sign=1, v=0, in_valid=1 → next cycle out_valid=1, out_result=0x5, out_wen=1, ovf_req=0.
- Compare codes:
  - ALUFun=110011 (EQ), z=0 → out_result=1. Same ALUFun with z=1 → 0.
  - ALUFun=111111 (GTZ), n=0, z=1 → 1.
  - ALUFun=110101 (LT), n=1 → 1.
- Signed overflow:
  - S=0x80000000, v=1, Sign=1, ALUFun=000000, pc=0x00400010 → out_wen=0, ovf_req=1, ovf_pc=0x00400010, ovf_cnt=1.
  - Same op with Sign=0 → out_wen=1, ovf_req=0.
- Request hold and ack:
  - Hold ovf_ack=0 for 5 cycles → ovf_req stays 1.
  - Pulse ovf_ack → ovf_req=0 next cycle.
  - Ack plus a new overflow in the same cycle (pc=0x00400020) → ovf_req stays 1, ovf_pc=0x00400020, ovf_cnt=2.
- Stall and flush:
  - stall=1 with new input → outputs unchanged.
  - stall=1 and flush=1 together → out_valid=0 next cycle.
  - With ovf_req=1, assert flush → ovf_req remains 1.
- Reset and saturation:
  - With CNTW=4, issue 17 overflows → ovf_cnt=0xF.
  - Drop reset asynchronously between clock edges → all outputs 0 at once, FSM in IDLE.

Source files
------------

// File: rtl/alu_result_stage.sv
// Execute result register behind the add/sub unit: picks sum or compare bit, traps signed overflow.
// One-cycle latency; stall freezes the stage, flush kills the op, and an overflow request is held until acknowledged.
module alu_result_stage #(
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [DW-1:0]   S,
  input  logic            z,
  input  logic            v,
  input  logic            n,
  input  logic [5:0]      ALUFun,
  input  logic            Sign,
  input  logic [DW-1:0]   pc,
  output logic            out_valid,
  output logic [DW-1:0]   out_result,
  output logic            out_wen,
  output logic            ovf_req,
  output logic [DW-1:0]   ovf_pc,
  input  logic            ovf_ack,
  output logic [CNTW-1:0] ovf_cnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t        state, state_nxt;
  logic          capture;
  logic          trap;
  logic          hold;
  logic          cmp_bit;
  logic          pc_load;
  logic [DW-1:0] result;
  logic          unused_fun0;

  assign unused_fun0 = ALUFun[0];

  assign capture = in_valid & ~stall & ~flush;
  assign hold    = stall & ~flush;
  assign trap    = capture & (ALUFun[5:4] == 2'b00) & Sign & v;

  // z is the "nonzero" flag, so equality is its inverse
  always_comb begin
    cmp_bit = 1'b0;
    case (ALUFun[3:1])
      3'b001:  cmp_bit = ~z;
      3'b000:  cmp_bit = z;
      3'b010:  cmp_bit = n;
      3'b110:  cmp_bit = n | ~z;
      3'b101:  cmp_bit = n;
      3'b111:  cmp_bit = ~n & z;
      default: cmp_bit = 1'b0;
    endcase
  end

  always_comb begin
    result = S;
    if (ALUFun[5:4] == 2'b11)
      result = {{(DW-1){1'b0}}, cmp_bit};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trap) state_nxt = REQ;
      REQ:     if (ovf_ack && !trap && !hold) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A new fault only replaces the latched PC once the previous one is acknowledged
  always_comb begin
    ovf_req = (state == REQ);
    pc_load = trap & ((state == IDLE) | ovf_ack);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_wen    <= 1'b0;
      out_result <= '0;
      ovf_pc     <= '0;
      ovf_cnt    <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
        out_wen   <= 1'b0;
      end else if (!stall) begin
        out_valid <= in_valid;
        out_wen   <= in_valid & ~trap;
      end
      if (capture)
        out_result <= result;
      if (pc_load)
        ovf_pc <= pc;
      if (trap && (ovf_cnt != {CNTW{1'b1}}))
        ovf_cnt <= ovf_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage, built with a 4-bit overflow counter to reach saturation quickly.
module tb_alu_result_stage;

  localparam int DW   = 32;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, stall, flush;
  logic [DW-1:0]   S;
  logic            z, v, n;
  logic [5:0]      ALUFun;
  logic            Sign;
  logic [DW-1:0]   pc;
  logic            out_valid;
  logic [DW-1:0]   out_result;
  logic            out_wen;
  logic            ovf_req;
  logic [DW-1:0]   ovf_pc;
  logic            ovf_ack;
  logic [CNTW-1:0] ovf_cnt;

  int ncmp = 0;
  int nerr = 0;

  alu_result_stage #(.DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .S(S), .z(z), .v(v), .n(n), .ALUFun(ALUFun), .Sign(Sign), .pc(pc),
    .out_valid(out_valid), .out_result(out_result), .out_wen(out_wen),
    .ovf_req(ovf_req), .ovf_pc(ovf_pc), .ovf_ack(ovf_ack), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic iv, input logic [5:0] fun, input logic sg,
                    input logic vv, input logic zz, input logic nn,
                    input logic [31:0] s, input logic [31:0] p);
    in_valid = iv; ALUFun = fun; Sign = sg; v = vv; z = zz; n = nn; S = s; pc = p;
    tick();
  endtask

  initial begin
    reset = 1'b0; in_valid = 0; stall = 0; flush = 0; S = '0; z = 0; v = 0; n = 0;
    ALUFun = '0; Sign = 0; pc = '0; ovf_ack = 0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_wen", out_wen, 0);
    chk("rst_req", ovf_req, 0);
    chk("rst_pc", ovf_pc, 0);
    chk("rst_cnt", ovf_cnt, 0);
    #1 reset = 1'b1;

    op(1, 6'b000000, 1, 0, 0, 0, 32'h5, 32'h0040_0000);
    chk("arith_valid", out_valid, 1);
    chk("arith_result", out_result, 32'h5);
    chk("arith_wen", out_wen, 1);
    chk("arith_req", ovf_req, 0);

    op(1, 6'b110011, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("eq_z0", out_result, 1);
    op(1, 6'b110011, 0, 0, 1, 0, 32'h7, 32'h0);
    chk("eq_z1", out_result, 0);
    op(1, 6'b111111, 1, 0, 1, 0, 32'h7, 32'h0);
    chk("gtz", out_result, 1);
    op(1, 6'b110101, 1, 0, 1, 1, 32'hffff_fffe, 32'h0);
    chk("lt", out_result, 1);
    op(1, 6'b110001, 0, 0, 1, 0, 32'h3, 32'h0);
    chk("ne", out_result, 1);
    op(1, 6'b110111, 0, 0, 1, 1, 32'h3, 32'h0);
    chk("cmp_other", out_result, 0);
    op(1, 6'b110011, 1, 1, 0, 0, 32'h0, 32'h0);
    chk("cmp_v_result", out_result, 1);
    chk("cmp_v_wen", out_wen, 1);
    chk("cmp_v_req", ovf_req, 0);
    op(1, 6'b010000, 1, 1, 1, 0, 32'hdead_beef, 32'h0);
    chk("fun01_result", out_result, 32'hdead_beef);
    chk("fun01_req", ovf_req, 0);

    op(0, 6'b000000, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("idle_valid", out_valid, 0);
    chk("idle_wen", out_wen, 0);

    op(1, 6'b000000, 0, 1, 1, 1, 32'h8000_0000, 32'h0040_000c);
    chk("unsigned_wen", out_wen, 1);
    chk("unsigned_req", ovf_req, 0);
    chk("unsigned_cnt", ovf_cnt, 0);

    op(1, 6'b000000, 1, 1, 1, 1, 32'h8000_0000, 32'h0040_0010);
    chk("ovf_valid", out_valid, 1);
    chk("ovf_wen", out_wen, 0);
    chk("ovf_req", ovf_req, 1);
    chk("ovf_pc", ovf_pc, 32'h0040_0010);
    chk("ovf_cnt1", ovf_cnt, 1);

    for (int i = 0; i < 5; i++) begin
      op(0, 6'b000000, 0, 0, 0, 0, 32'h0, 32'h0);
      chk("hold_req", ovf_req, 1);
    end
    chk("hold_pc", ovf_pc, 32'h0040_0010);

    ovf_ack = 1;
    op(0, 6'b000000, 0, 0, 0, 0, 32'h0, 32'h0);
    ovf_ack = 0;
    chk("ack_req", ovf_req, 0);

    op(1, 6'b000000, 1, 1, 1, 1, 32'h8000_0000, 32'h0040_0018);
    chk("ovf2_req", ovf_req, 1);
    chk("ovf2_pc", ovf_pc, 32'h0040_0018);
    ovf_ack = 1;
    op(1, 6'b000000, 1, 1, 1, 0, 32'h7fff_ffff, 32'h0040_0020);
    ovf_ack = 0;
    chk("ackovf_req", ovf_req, 1);
    chk("ackovf_pc", ovf_pc, 32'h0040_0020);
    chk("ackovf_cnt", ovf_cnt, 3);
    op(1, 6'b000000, 1, 1, 1, 1, 32'h8000_0000, 32'h0040_0024);
    chk("firstwins_pc", ovf_pc, 32'h0040_0020);
    chk("firstwins_cnt", ovf_cnt, 4);

    flush = 1;
    op(1, 6'b000000, 1, 1, 1, 1, 32'h8000_0000, 32'h0040_0028);
    flush = 0;
    chk("flush_valid", out_valid, 0);
    chk("flush_req", ovf_req, 1);
    chk("flush_cnt", ovf_cnt, 4);
    chk("flush_pc", ovf_pc, 32'h0040_0020);

    op(1, 6'b000000, 0, 0, 1, 0, 32'h1234, 32'h0);
    chk("pre_stall_result", out_result, 32'h1234);
    stall = 1;
    op(1, 6'b000000, 0, 0, 1, 0, 32'h9999, 32'h0);
    chk("stall_result", out_result, 32'h1234);
    chk("stall_valid", out_valid, 1);
    chk("stall_wen", out_wen, 1);
    flush = 1;
    op(1, 6'b000000, 0, 0, 1, 0, 32'h5555, 32'h0);
    stall = 0; flush = 0;
    chk("stallflush_valid", out_valid, 0);
    chk("stallflush_wen", out_wen, 0);
    chk("stallflush_result", out_result, 32'h1234);

    ovf_ack = 1;
    op(0, 6'b000000, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("ack2_req", ovf_req, 0);
    op(0, 6'b000000, 0, 0, 0, 0, 32'h0, 32'h0);
    ovf_ack = 0;
    chk("idle_ack_req", ovf_req, 0);

    for (int i = 0; i < 17; i++)
      op(1, 6'b000000, 1, 1, 1, 1, 32'h8000_0000, 32'h0040_0100 + 32'(i * 4));
    chk("sat_cnt", ovf_cnt, 4'hf);
    chk("sat_req", ovf_req, 1);
    chk("sat_pc", ovf_pc, 32'h0040_0100);

    in_valid = 0;
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_result", out_result, 0);
    chk("arst_wen", out_wen, 0);
    chk("arst_req", ovf_req, 0);
    chk("arst_pc", ovf_pc, 0);
    chk("arst_cnt", ovf_cnt, 0);
    #1 reset = 1'b1;
    ovf_ack = 1;
    op(0, 6'b000000, 0, 0, 0, 0, 32'h0, 32'h0);
    ovf_ack = 0;
    chk("post_rst_req", ovf_req, 0);
    op(1, 6'b000000, 1, 1, 1, 1, 32'h8000_0000, 32'h0040_0200);
    chk("post_rst_ovf_req", ovf_req, 1);
    chk("post_rst_ovf_cnt", ovf_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
